alu_arbiter: RTL

Two-port arbiter and pipeline controller that shares the single combinational ALU between two requesters, e.g. execute stage (port 0) and address-generation unit (port 1). Accepts one operation per cycle over valid/ready handshakes, drives the shared ALU from a registered operand stage, and returns a registered result plus flags to the winning port two cycles after acceptance. Sits between the requesters and the ALU instance; the ALU itself is external.

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter and two-stage pipeline in front of a shared external ALU.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins ties.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_src1_0,
    input  logic [15:0] req_src1_1,
    input  logic [15:0] req_src2_0,
    input  logic [15:0] req_src2_1,
    input  logic [2:0]  req_op_0,
    input  logic [2:0]  req_op_1,
    output logic [15:0] alu_src1,
    output logic [15:0] alu_src2,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic [1:0]  resp_valid,
    output logic [15:0] resp_result,
    output logic [3:0]  resp_flags,
    output logic        busy
);
    localparam int DATA_W = 16;
    localparam int OP_W   = 3;
    localparam int FLAG_W = 4;

    // Issue stage (p0) and result stage (p1) state
    logic              vld_p0_q, vld_p0_d;
    logic              port_p0_q, port_p0_d;
    logic [DATA_W-1:0] src1_p0_q, src2_p0_q;
    logic [OP_W-1:0]   op_p0_q;
    logic              vld_p1_q, vld_p1_d;
    logic              port_p1_q, port_p1_d;
    logic [DATA_W-1:0] result_p1_q, result_p1_d;
    logic [FLAG_W-1:0] flags_p1_q, flags_p1_d;
    logic              last_q, last_d;

    logic              gnt_port;
    logic              accept;

    // Grant: combinational from request valids, stall and the last-grant state
    always_comb begin
        req_ready = 2'b00;
        gnt_port  = 1'b0;
        if (rst_n && !stall) begin
            case (req_valid)
                2'b01: req_ready = 2'b01;
                2'b10: begin
                    req_ready = 2'b10;
                    gnt_port  = 1'b1;
                end
                2'b11: begin
`ifdef ARB_RR_EN
                    gnt_port  = ~last_q;
                    req_ready = last_q ? 2'b01 : 2'b10;
`else
                    req_ready = 2'b01;
`endif
                end
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        vld_p0_d    = vld_p0_q;
        port_p0_d   = port_p0_q;
        last_d      = last_q;
        vld_p1_d    = vld_p1_q;
        port_p1_d   = port_p1_q;
        result_p1_d = result_p1_q;
        flags_p1_d  = flags_p1_q;
        if (!stall) begin
            vld_p0_d = accept;
            if (accept) begin
                port_p0_d = gnt_port;
                last_d    = gnt_port;
            end
            vld_p1_d = vld_p0_q;
            // Result registers only move on a real operation so they hold across bubbles
            if (vld_p0_q) begin
                port_p1_d   = port_p0_q;
                result_p1_d = alu_result;
                flags_p1_d  = alu_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0_q    <= 1'b0;
            port_p0_q   <= 1'b0;
            last_q      <= 1'b1;
            vld_p1_q    <= 1'b0;
            port_p1_q   <= 1'b0;
            result_p1_q <= '0;
            flags_p1_q  <= '0;
        end else begin
            vld_p0_q    <= vld_p0_d;
            port_p0_q   <= port_p0_d;
            last_q      <= last_d;
            vld_p1_q    <= vld_p1_d;
            port_p1_q   <= port_p1_d;
            result_p1_q <= result_p1_d;
            flags_p1_q  <= flags_p1_d;
        end
    end

    // Issue-stage operands: loaded only on accept, which already implies reset released and no stall
    always_ff @(posedge clk) begin
        if (accept) begin
            src1_p0_q <= gnt_port ? req_src1_1 : req_src1_0;
            src2_p0_q <= gnt_port ? req_src2_1 : req_src2_0;
            op_p0_q   <= gnt_port ? req_op_1   : req_op_0;
        end
    end

    assign alu_src1 = rst_n ? src1_p0_q : '0;
    assign alu_src2 = rst_n ? src2_p0_q : '0;
    assign alu_op   = rst_n ? op_p0_q   : '0;

    // Result stage outputs
    assign resp_valid[0] = rst_n && vld_p1_q && !port_p1_q && !stall;
    assign resp_valid[1] = rst_n && vld_p1_q &&  port_p1_q && !stall;
    assign resp_result   = result_p1_q;
    assign resp_flags    = flags_p1_q;
    assign busy          = rst_n && (vld_p0_q || vld_p1_q);

endmodule
